// File: rtl/keypad_entry_ctrl.sv
// Debounces decoded keypad codes and runs record-mode entry into a three-digit buffer.
// Digits shift in from the right; A/B/C start, stop and clear recording, and idle time ends it.
module keypad_entry_ctrl #(
    parameter int DEB_CYC = 4,
    parameter int TMO_CYC = 1000
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       key_vld,
    input  logic [3:0] key_val,
    output logic [3:0] DispVal,
    output logic [3:0] DispVal2,
    output logic [3:0] DispVal3,
    output logic       isRecord,
    output logic [1:0] digit_cnt,
    output logic       entry_done
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } deb_state_t;

    deb_state_t    state;
    logic [3:0]    cand;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          accept;

    // Combinational so the action lands on the same edge that completes the debounce count.
    assign accept = (state == PRESS_DEB) && key_vld && (key_val == cand)
                    && (deb_cnt == DW'(DEB_CYC - 1));

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= 4'd0;
            deb_cnt    <= '0;
            tmo_cnt    <= '0;
            DispVal    <= 4'd0;
            DispVal2   <= 4'd0;
            DispVal3   <= 4'd0;
            isRecord   <= 1'b0;
            digit_cnt  <= 2'd0;
            entry_done <= 1'b0;
        end else begin
            entry_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (key_vld) begin
                        cand    <= key_val;
                        deb_cnt <= DW'(1);
                        state   <= PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (!key_vld) begin
                        state <= IDLE;
                    end else if (key_val != cand) begin
                        cand    <= key_val;
                        deb_cnt <= DW'(1);
                    end else if (accept) begin
                        state <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    // Code changes while held are ignored: no repeat, no roll-over.
                    if (!key_vld) begin
                        deb_cnt <= DW'(1);
                        state   <= REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (key_vld) begin
                        state <= HELD;
                    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                tmo_cnt <= '0;
                case (cand)
                    4'hA: begin
                        isRecord  <= 1'b1;
                        DispVal   <= 4'd0;
                        DispVal2  <= 4'd0;
                        DispVal3  <= 4'd0;
                        digit_cnt <= 2'd0;
                    end
                    4'hB: begin
                        if (isRecord) begin
                            isRecord   <= 1'b0;
                            entry_done <= 1'b1;
                        end
                    end
                    4'hC: begin
                        DispVal   <= 4'd0;
                        DispVal2  <= 4'd0;
                        DispVal3  <= 4'd0;
                        digit_cnt <= 2'd0;
                    end
                    default: begin
                        if (cand <= 4'd9 && isRecord && digit_cnt != 2'd3) begin
                            DispVal   <= DispVal2;
                            DispVal2  <= DispVal3;
                            DispVal3  <= cand;
                            digit_cnt <= digit_cnt + 2'd1;
                        end
                    end
                endcase
            end else if (!isRecord) begin
                tmo_cnt <= '0;
            end else if (state == IDLE) begin
                // Idle time only accrues with no key activity; a partial press holds the count.
                if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                    isRecord   <= 1'b0;
                    entry_done <= 1'b1;
                    tmo_cnt    <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with DEB_CYC=4 and TMO_CYC=20.
// Inputs change and outputs are sampled on the falling edge of fclk.
module tb_keypad_entry_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 20;

    logic       fclk = 1'b0;
    logic       rst = 1'b1;
    logic       key_vld = 1'b0;
    logic [3:0] key_val = 4'd0;
    logic [3:0] DispVal;
    logic [3:0] DispVal2;
    logic [3:0] DispVal3;
    logic       isRecord;
    logic [1:0] digit_cnt;
    logic       entry_done;

    int n_checks = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int acc_base = 0;
    logic [3:0] exp_q[$];

    keypad_entry_ctrl #(
        .DEB_CYC(DEB),
        .TMO_CYC(TMO)
    ) dut (
        .fclk      (fclk),
        .rst       (rst),
        .key_vld   (key_vld),
        .key_val   (key_val),
        .DispVal   (DispVal),
        .DispVal2  (DispVal2),
        .DispVal3  (DispVal3),
        .isRecord  (isRecord),
        .digit_cnt (digit_cnt),
        .entry_done(entry_done)
    );

    // clock / reset
    always #5 fclk = ~fclk;

    always @(posedge fclk) begin
        if (dut.accept) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d1, input logic [3:0] d2,
                           input logic [3:0] d3, input logic [1:0] cnt, input logic rec);
        check({tag, "_d1"}, 32'(DispVal), 32'(d1));
        check({tag, "_d2"}, 32'(DispVal2), 32'(d2));
        check({tag, "_d3"}, 32'(DispVal3), 32'(d3));
        check({tag, "_cnt"}, 32'(digit_cnt), 32'(cnt));
        check({tag, "_rec"}, 32'(isRecord), 32'(rec));
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        key_val = k;
        key_vld = 1'b1;
        tick(hold);
        key_vld = 1'b0;
        tick(gap);
    endtask

    initial begin
        tick(2);
        chk_out("reset", 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        check("reset_done", 32'(entry_done), 32'd0);
        rst = 1'b0;
        tick(2);

        // record entry: A, 1, 2, 3, 4 (4 dropped), then B
        press(4'hA, 10, 10);
        chk_out("a_start", 4'd0, 4'd0, 4'd0, 2'd0, 1'b1);
        key_val = 4'd1;
        key_vld = 1'b1;
        tick(DEB - 1);
        check("lat_pre_cnt", 32'(digit_cnt), 32'd0);
        tick(1);
        check("lat_post_cnt", 32'(digit_cnt), 32'd1);
        check("lat_post_d3", 32'(DispVal3), 32'd1);
        tick(6);
        key_vld = 1'b0;
        tick(10);
        press(4'd2, 10, 10);
        press(4'd3, 10, 10);
        press(4'd4, 10, 10);
        exp_q = '{4'd1, 4'd2, 4'd3};
        chk_out("entry", exp_q[0], exp_q[1], exp_q[2], 2'd3, 1'b1);

        key_val = 4'hB;
        key_vld = 1'b1;
        tick(DEB - 1);
        check("b_pre_rec", 32'(isRecord), 32'd1);
        check("b_pre_done", 32'(entry_done), 32'd0);
        tick(1);
        check("b_rec", 32'(isRecord), 32'd0);
        check("b_done", 32'(entry_done), 32'd1);
        tick(1);
        check("b_done_clr", 32'(entry_done), 32'd0);
        tick(5);
        key_vld = 1'b0;
        tick(10);
        chk_out("b_keep", exp_q[0], exp_q[1], exp_q[2], 2'd3, 1'b0);

        // ignored keys while not recording, then C clears
        press(4'd5, 10, 10);
        chk_out("idle_digit", 4'd1, 4'd2, 4'd3, 2'd3, 1'b0);
        key_val = 4'hB;
        key_vld = 1'b1;
        tick(DEB);
        check("idle_b_done", 32'(entry_done), 32'd0);
        tick(6);
        key_vld = 1'b0;
        tick(10);
        press(4'hD, 10, 10);
        press(4'hE, 10, 10);
        press(4'hF, 10, 10);
        chk_out("idle_def", 4'd1, 4'd2, 4'd3, 2'd3, 1'b0);
        press(4'hC, 10, 10);
        chk_out("idle_c", 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);

        // bounce rejection while recording
        press(4'hA, 10, 10);
        acc_base = acc_cnt;
        key_val = 4'd5;
        key_vld = 1'b1; tick(1);
        key_vld = 1'b0; tick(1);
        key_vld = 1'b1; tick(1);
        key_vld = 1'b0; tick(4);
        check("bounce_acc", 32'(acc_cnt - acc_base), 32'd0);
        check("bounce_cnt", 32'(digit_cnt), 32'd0);
        acc_base = acc_cnt;
        key_vld = 1'b1; tick(6);
        key_vld = 1'b0; tick(2);
        key_vld = 1'b1; tick(6);
        key_vld = 1'b0; tick(10);
        check("glitch_acc", 32'(acc_cnt - acc_base), 32'd1);
        chk_out("glitch", 4'd0, 4'd0, 4'd5, 2'd1, 1'b1);
        press(4'hD, 10, 10);
        press(4'hE, 10, 10);
        press(4'hF, 10, 10);
        chk_out("rec_def", 4'd0, 4'd0, 4'd5, 2'd1, 1'b1);

        // candidate change: 7 for two cycles, then 8
        key_val = 4'd7;
        key_vld = 1'b1;
        tick(2);
        key_val = 4'd8;
        tick(3);
        check("cand_pre_cnt", 32'(digit_cnt), 32'd1);
        tick(1);
        chk_out("cand_post", 4'd0, 4'd5, 4'd8, 2'd2, 1'b1);
        tick(4);
        key_vld = 1'b0;
        tick(10);
        press(4'hC, 10, 10);
        chk_out("rec_c", 4'd0, 4'd0, 4'd0, 2'd0, 1'b1);

        // inactivity timeout
        press(4'hA, 10, 10);
        press(4'd9, 10, 0);
        tick(DEB + TMO - 1);
        check("tmo_pre_rec", 32'(isRecord), 32'd1);
        check("tmo_pre_done", 32'(entry_done), 32'd0);
        tick(1);
        chk_out("tmo_hit", 4'd0, 4'd0, 4'd9, 2'd1, 1'b0);
        check("tmo_done", 32'(entry_done), 32'd1);
        tick(1);
        check("tmo_done_clr", 32'(entry_done), 32'd0);

        // reset while a key is held mid-record
        press(4'hA, 10, 10);
        press(4'd5, 10, 10);
        press(4'd6, 10, 10);
        key_val = 4'd7;
        key_vld = 1'b1;
        tick(6);
        chk_out("pre_rst", 4'd5, 4'd6, 4'd7, 2'd3, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk_out("rst_async", 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        check("rst_async_done", 32'(entry_done), 32'd0);
        tick(2);
        rst = 1'b0;
        acc_base = acc_cnt;
        tick(DEB - 1);
        check("rel_acc_pre", 32'(acc_cnt - acc_base), 32'd0);
        tick(1);
        check("rel_acc_once", 32'(acc_cnt - acc_base), 32'd1);
        tick(10);
        check("rel_acc_hold", 32'(acc_cnt - acc_base), 32'd1);
        chk_out("rel_out", 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        key_vld = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
